obi_mem_arbiter: RTL and testbench

// - Merges the instruction-side and data-side OBI master ports of the cache memory

---
 rtl/obi_mem_arbiter_if.sv | 30 +++
 rtl/obi_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_obi_mem_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/obi_mem_arbiter_if.sv
// OBI request/response bundle shared by the arbiter's three ports.
//   req/addr/we/be/wdata : address phase, driven by the master
//   gnt                  : address-phase acceptance, driven by the slave
//   rvalid/rdata         : response phase, driven by the slave
// Modports:
//   master : the side issuing requests (drives req/addr/we/be/wdata)
//   slave  : the side answering requests (drives gnt/rvalid/rdata)
interface obi_mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    req;
  logic                    gnt;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/obi_mem_arbiter.sv
// Merges the instruction-side and data-side OBI masters onto one OBI master
// port toward system memory. Round-robin arbitration, address-phase lock while
// a request waits for grant, and in-order response routing via an ID FIFO of
// accepted-but-unanswered transactions.
// Ports:
//   clk_i          : clock, all state on rising edge
//   rst_ni         : asynchronous active-low reset
//   instr          : instruction master (slave side of the bundle)
//   data           : data master (slave side of the bundle)
//   mem            : shared port toward memory (master side of the bundle)
//   spurious_rsp_o : sticky flag, response seen with nothing outstanding
module obi_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  obi_mem_arbiter_if.slave    instr,
  obi_mem_arbiter_if.slave    data,
  obi_mem_arbiter_if.master   mem,
  output logic                spurious_rsp_o
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {
    ID_INSTR = 1'b0,
    ID_DATA  = 1'b1
  } master_id_e;

  master_id_e       id_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             lock_q;
  master_id_e       lock_owner_q;
  master_id_e       last_grant_q;
  logic             spurious_q;

  logic       any_req;
  logic       full;
  logic       empty;
  logic       accept;
  logic       pop;
  master_id_e sel;
  master_id_e head;

  assign any_req = instr.req | data.req;
  assign full    = (count == CNT_MAX);
  assign empty   = (count == '0);
  assign mem.req = any_req & ~full;
  assign accept  = mem.req & mem.gnt;
  assign pop     = mem.rvalid & ~empty;
  assign head    = id_fifo[rd_ptr];

  // A stalled request keeps the port (lock) so the address phase cannot switch
  // masters before the grant; otherwise alternate on ties.
  always_comb begin
    sel = ID_INSTR;
    if (lock_q) begin
      sel = lock_owner_q;
    end else if (instr.req && !data.req) begin
      sel = ID_INSTR;
    end else if (data.req && !instr.req) begin
      sel = ID_DATA;
    end else if (instr.req && data.req) begin
      sel = (last_grant_q == ID_DATA) ? ID_INSTR : ID_DATA;
    end
  end

  always_comb begin
    mem.addr  = '0;
    mem.we    = 1'b0;
    mem.be    = '0;
    mem.wdata = '0;
    if (any_req) begin
      if (sel == ID_DATA) begin
        mem.addr  = data.addr;
        mem.we    = data.we;
        mem.be    = data.be;
        mem.wdata = data.wdata;
      end else begin
        mem.addr  = instr.addr;
        mem.we    = instr.we;
        mem.be    = instr.be;
        mem.wdata = instr.wdata;
      end
    end
  end

  assign instr.gnt    = accept & (sel == ID_INSTR);
  assign data.gnt     = accept & (sel == ID_DATA);
  assign instr.rvalid = pop & (head == ID_INSTR);
  assign data.rvalid  = pop & (head == ID_DATA);
  assign instr.rdata  = mem.rdata;
  assign data.rdata   = mem.rdata;
  assign spurious_rsp_o = spurious_q;

  // ID storage needs no reset: only entries between rd_ptr and wr_ptr are read.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      id_fifo[wr_ptr] <= sel;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      lock_q       <= 1'b0;
      lock_owner_q <= ID_INSTR;
      last_grant_q <= ID_DATA;
      spurious_q   <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr       <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
        last_grant_q <= sel;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Set on a stalled request, cleared by the owner's handshake; folding
      // both into one expression also drops a lock if the request vanishes.
      lock_q       <= mem.req & ~mem.gnt;
      lock_owner_q <= sel;
      if (mem.rvalid && empty) begin
        spurious_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
module tb_obi_mem_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int MAXO  = 4;
  localparam int OBS_W = 6 + AW + 1 + BW + DW + 2 * DW;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic spurious_rsp_o;

  always #5 clk_i = ~clk_i;

  obi_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ibus ();
  obi_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dbus ();
  obi_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mbus ();

  obi_mem_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .instr(ibus),
    .data(dbus),
    .mem(mbus),
    .spurious_rsp_o(spurious_rsp_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: list of outstanding owners (0=instr, 1=data),
  // last granted master, pending (granted-not-yet) owner, sticky error.
  int  q[$];
  int  m_last;
  bit  m_pend;
  int  m_pend_id;
  bit  m_spur;
  bit  m_req, m_acc, m_pop;
  int  m_sel;
  logic [OBS_W-1:0] exp_v;

  function automatic logic [OBS_W-1:0] obs();
    return {mbus.req, ibus.gnt, dbus.gnt, ibus.rvalid, dbus.rvalid, spurious_rsp_o,
            mbus.addr, mbus.we, mbus.be, mbus.wdata, ibus.rdata, dbus.rdata};
  endfunction

  task automatic model_reset();
    q.delete();
    m_last    = 1;
    m_pend    = 1'b0;
    m_pend_id = 0;
    m_spur    = 1'b0;
  endtask

  task automatic model_eval();
    bit ir, dr, any, hd;
    logic [AW-1:0] a; logic w; logic [BW-1:0] b; logic [DW-1:0] wd;
    ir  = ibus.req;
    dr  = dbus.req;
    any = ir | dr;
    m_req = any && (q.size() < MAXO);
    if (m_pend)        m_sel = m_pend_id;
    else if (ir && !dr) m_sel = 0;
    else if (dr && !ir) m_sel = 1;
    else if (ir && dr)  m_sel = (m_last == 1) ? 0 : 1;
    else                m_sel = 0;
    a = '0; w = 1'b0; b = '0; wd = '0;
    if (any) begin
      a  = (m_sel == 1) ? dbus.addr  : ibus.addr;
      w  = (m_sel == 1) ? dbus.we    : ibus.we;
      b  = (m_sel == 1) ? dbus.be    : ibus.be;
      wd = (m_sel == 1) ? dbus.wdata : ibus.wdata;
    end
    m_acc = m_req && mbus.gnt;
    m_pop = mbus.rvalid && (q.size() > 0);
    hd    = (q.size() > 0) ? q[0][0] : 1'b0;
    exp_v = {m_req, m_acc && m_sel == 0, m_acc && m_sel == 1,
             m_pop && !hd, m_pop && hd, m_spur,
             a, w, b, wd, mbus.rdata, mbus.rdata};
  endtask

  task automatic model_commit();
    if (mbus.rvalid && q.size() == 0) m_spur = 1'b1;
    if (m_pop) void'(q.pop_front());
    if (m_acc) begin
      q.push_back(m_sel);
      m_last = m_sel;
    end
    m_pend    = m_req && !mbus.gnt;
    m_pend_id = m_sel;
  endtask

  // Entry/exit phase of every cycle is posedge+1.
  task automatic settle();
    #4;
    model_eval();
  endtask

  task automatic advance();
    model_commit();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    ibus.req = 0; ibus.addr = '0; ibus.we = 0; ibus.be = '0; ibus.wdata = '0;
    dbus.req = 0; dbus.addr = '0; dbus.we = 0; dbus.be = '0; dbus.wdata = '0;
    mbus.gnt = 0; mbus.rvalid = 0; mbus.rdata = '0;
  endtask

  task automatic drive_master(input bit is_data, input bit req);
    if (is_data) begin
      dbus.req = req; dbus.addr = AW'($urandom); dbus.we = 1'($urandom);
      dbus.be = BW'($urandom); dbus.wdata = DW'($urandom);
    end else begin
      ibus.req = req; ibus.addr = AW'($urandom); ibus.we = 1'($urandom);
      ibus.be = BW'($urandom); ibus.wdata = DW'($urandom);
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    model_reset();
    #6;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 1'b0;
    model_reset();
    #2;
    model_eval();
    n_tests++;
    if (obs() !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected all zero", obs());
    end
    n_tests++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL reset_model: got %h expected %h", obs(), exp_v);
    end
    @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_instr_only();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive_master(0, 1);
      ibus.we = 0;
      mbus.gnt = 1;
      mbus.rvalid = (i > 0);
      mbus.rdata = DW'($urandom);
      settle();
      n_tests++;
      if (obs() !== exp_v) begin
        n_fail++;
        $display("FAIL instr_only_model cycle %0d: got %h expected %h", i, obs(), exp_v);
      end
      n_tests++;
      if ({ibus.gnt, ibus.rvalid, dbus.gnt, dbus.rvalid} !== {1'b1, i > 0, 2'b00}) begin
        n_fail++;
        $display("FAIL instr_only_hs cycle %0d: got %b expected %b", i,
                 {ibus.gnt, ibus.rvalid, dbus.gnt, dbus.rvalid}, {1'b1, i > 0, 2'b00});
      end
      advance();
    end
    idle_inputs();
    settle();
    advance();
  endtask

  task automatic test_alternate();
    logic [3:0] want;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive_master(0, 1);
      drive_master(1, 1);
      mbus.gnt = 1;
      mbus.rvalid = (i > 0);
      mbus.rdata = DW'($urandom);
      settle();
      // {instr gnt, data gnt, instr rvalid, data rvalid}
      want = {i % 2 == 0, i % 2 == 1, i > 0 && (i - 1) % 2 == 0, i > 0 && (i - 1) % 2 == 1};
      n_tests++;
      if ({ibus.gnt, dbus.gnt, ibus.rvalid, dbus.rvalid} !== want) begin
        n_fail++;
        $display("FAIL alternate cycle %0d: got %b expected %b", i,
                 {ibus.gnt, dbus.gnt, ibus.rvalid, dbus.rvalid}, want);
      end
      n_tests++;
      if (obs() !== exp_v) begin
        n_fail++;
        $display("FAIL alternate_model cycle %0d: got %h expected %h", i, obs(), exp_v);
      end
      advance();
    end
    idle_inputs();
    mbus.rvalid = 1;
    settle();
    advance();
  endtask

  task automatic test_lock();
    logic [AW-1:0] da, ia;
    logic [AW+1:0] want;
    da = 32'hD000_0040;
    ia = 32'h1000_0100;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      dbus.req = (i < 4); dbus.addr = da; dbus.be = '1;
      ibus.req = (i >= 1); ibus.addr = ia; ibus.be = '1;
      mbus.gnt = (i >= 3);
      settle();
      // {mem addr, instr gnt, data gnt}
      if (i < 3)       want = {da, 2'b00};
      else if (i == 3) want = {da, 2'b01};
      else             want = {ia, 2'b10};
      n_tests++;
      if ({mbus.addr, ibus.gnt, dbus.gnt} !== want) begin
        n_fail++;
        $display("FAIL lock cycle %0d: got %h expected %h", i, {mbus.addr, ibus.gnt, dbus.gnt}, want);
      end
      n_tests++;
      if (obs() !== exp_v) begin
        n_fail++;
        $display("FAIL lock_model cycle %0d: got %h expected %h", i, obs(), exp_v);
      end
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_full();
    logic [2:0] want;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive_master(0, 1);
      mbus.gnt = 1;
      mbus.rvalid = (i == 5);
      mbus.rdata = DW'($urandom);
      settle();
      // {mem req, instr gnt, instr rvalid}
      if (i < 4)       want = 3'b110;
      else if (i == 4) want = 3'b000;
      else if (i == 5) want = 3'b001;
      else             want = 3'b110;
      n_tests++;
      if ({mbus.req, ibus.gnt, ibus.rvalid} !== want) begin
        n_fail++;
        $display("FAIL full cycle %0d: got %b expected %b", i, {mbus.req, ibus.gnt, ibus.rvalid}, want);
      end
      n_tests++;
      if (obs() !== exp_v) begin
        n_fail++;
        $display("FAIL full_model cycle %0d: got %h expected %h", i, obs(), exp_v);
      end
      advance();
    end
    idle_inputs();
  endtask

  // Entered with the FIFO full from test_full.
  task automatic test_spurious();
    logic [2:0] want;
    idle_inputs();
    mbus.rvalid = 1;
    settle();
    n_tests++;
    if ({ibus.rvalid, dbus.rvalid, spurious_rsp_o} !== 3'b100) begin
      n_fail++;
      $display("FAIL midburst_rsp: got %b expected 100", {ibus.rvalid, dbus.rvalid, spurious_rsp_o});
    end
    advance();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      idle_inputs();
      mbus.rvalid = (i == 0);
      if (i >= 4) begin
        drive_master(0, 1);
        mbus.gnt = 1;
      end
      settle();
      // {instr rvalid, data rvalid, spurious}; four accepts fit after reset
      want = {2'b00, i > 0};
      n_tests++;
      if ({ibus.rvalid, dbus.rvalid, spurious_rsp_o} !== want) begin
        n_fail++;
        $display("FAIL spurious cycle %0d: got %b expected %b", i,
                 {ibus.rvalid, dbus.rvalid, spurious_rsp_o}, want);
      end
      n_tests++;
      if (mbus.req !== (i >= 4 && i < 8)) begin
        n_fail++;
        $display("FAIL count_after_reset cycle %0d: got %b expected %b", i, mbus.req, i >= 4 && i < 8);
      end
      n_tests++;
      if (obs() !== exp_v) begin
        n_fail++;
        $display("FAIL spurious_model cycle %0d: got %h expected %h", i, obs(), exp_v);
      end
      advance();
    end
    do_reset();
    settle();
    n_tests++;
    if (spurious_rsp_o !== 1'b0) begin
      n_fail++;
      $display("FAIL spurious_clear: got %b expected 0", spurious_rsp_o);
    end
    advance();
  endtask

  task automatic test_random();
    bit i_pend, d_pend;
    int errs;
    i_pend = 0;
    d_pend = 0;
    errs = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      // Masters hold their request and payload until granted.
      if (!i_pend) drive_master(0, $urandom_range(0, 3) != 0);
      if (!d_pend) drive_master(1, $urandom_range(0, 3) != 0);
      mbus.gnt    = $urandom_range(0, 3) != 0;
      mbus.rvalid = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      mbus.rdata  = DW'($urandom);
      settle();
      n_tests++;
      if (obs() !== exp_v) begin
        n_fail++;
        errs++;
        if (errs < 10)
          $display("FAIL random cycle %0d: got %h expected %h", i, obs(), exp_v);
      end
      i_pend = ibus.req && !(m_acc && m_sel == 0);
      d_pend = dbus.req && !(m_acc && m_sel == 1);
      advance();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_instr_only();
    test_alternate();
    test_lock();
    test_full();
    test_spurious();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
